ram_dp_pipelined: RTL and testbench
===================================

// Module: ram_dp_pipelined
// PURPOSE
//  Simple dual-port block RAM (one write port, one read port, one clock) for the softmax
//  pipeline buffers. Generalises the single-port BRAM: concurrent read/write, byte
//  enables, selectable read latency with a valid strobe, defined collision behaviour.
//  Sits between pipeline stages as a score/exponent buffer; memory array infers BRAM.
// PARAMETERS
//  DATA_WIDTH   32    word width in bits; must be a multiple of 8 (elaboration error otherwise)
//  ADDR_WIDTH   10    address width
//  TOTAL_WORDS  1024  implemented depth; must be <= 2**ADDR_WIDTH
//  OUTPUT_REG   1     0: read latency 1 cycle; 1: extra output register, latency 2
//  WRITE_FIRST  0     0: same-address read returns old word; 1: returns newly written word
// PORTS
//  clock           in   1             rising-edge clock for all logic
//  reset_n         in   1             asynchronous, active-low reset
//  wr_enable       in   1             write request this cycle
//  wr_byte_enable  in   DATA_WIDTH/8  per-byte write mask, bit i -> wr_data[8i+7:8i]
//  wr_address      in   ADDR_WIDTH    write address
//  wr_data         in   DATA_WIDTH    write data
//  rd_enable       in   1             read request this cycle
//  rd_address      in   ADDR_WIDTH    read address
//  rd_data         out  DATA_WIDTH    read data, registered
//  rd_valid        out  1             rd_data carries the result of a read request
//  busy            out  1             block not accepting requests (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: rd_data=0, rd_valid=0, all latency-pipeline valid bits cleared; memory array
//    has no reset. Reset mid-operation discards in-flight reads; contents retained.
//  - Write: on clock edge with wr_enable=1 and busy=0, bytes with wr_byte_enable=1 updated;
//    other bytes unchanged. wr_byte_enable=0 with wr_enable=1 is a legal no-op.
//  - Read: rd_enable=1 at edge N -> rd_data/rd_valid at edge N+1+OUTPUT_REG; rd_valid
//    high exactly one cycle per request; back-to-back reads give one result per cycle.
//  - rd_data holds its last value when rd_valid=0 (no zeroing between reads).
//  - Collision (rd_address==wr_address, both enabled, same edge): WRITE_FIRST=0 -> old word;
//    WRITE_FIRST=1 -> per-byte merge: enabled bytes from wr_data, others from old word.
//  - Out of range (address >= TOTAL_WORDS): write ignored; read returns 0 with rd_valid=1.
//  - Read and write of different addresses are fully independent, no stall.
// CONFIGURATION
//  Macro RAM_INIT_CLEAR_EN:
//  - Defined: clear FSM, states CLEAR -> READY. Reset forces CLEAR, counter=0, busy=1.
//    CLEAR writes zero to address counter each cycle, counter+1; after writing address
//    TOTAL_WORDS-1 -> READY next edge, busy=0. Sweep takes TOTAL_WORDS cycles after
//    reset_n rises. While busy: wr_enable/rd_enable ignored, rd_valid stays 0.
//    Reset during CLEAR restarts sweep at address 0. READY is terminal until reset.
//  - Undefined: no FSM, busy tied 0, contents undefined at power-up; requests accepted
//    from first edge after reset_n rises.
// TESTING
//  - Write 0xDEADBEEF @5 mask 4'hF, then read @5 -> rd_data=0xDEADBEEF, rd_valid 1 cycle,
//    exactly 1+OUTPUT_REG edges after the read request (check both OUTPUT_REG values).
//  - @5=0xDEADBEEF, write 0x00001200 mask 4'b0010 -> read @5 returns 0xDEAD12EF.
//  - Same-edge write 0x11111111 / read @7 (old 0xAAAAAAAA): WRITE_FIRST=0 -> 0xAAAAAAAA;
//    WRITE_FIRST=1 -> 0x11111111; mask 4'b0001 with WRITE_FIRST=1 -> 0xAAAAAA11.
//  - Burst reads @0..15 on consecutive cycles -> 16 rd_valid pulses back-to-back, data in
//    address order; assert reset_n mid-burst -> rd_valid=0 and rd_data=0 immediately.
//  - TOTAL_WORDS=1000: write @1010 then read @1010 -> rd_data=0, rd_valid=1; word @0 unchanged.
//  - RAM_INIT_CLEAR_EN: busy=1 for 1024 cycles after reset_n rises, requests ignored;
//    then read @0 and @1023 -> 0; reset at sweep cycle 300 -> busy a further 1024 cycles.

Source files
------------

// File: rtl/ram_dp_pipelined_if.sv
// Request/response bundle for ram_dp_pipelined: one write port, one read port, busy flag.
interface ram_dp_pipelined_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                    wr_enable;
  logic [DATA_WIDTH/8-1:0] wr_byte_enable;
  logic [ADDR_WIDTH-1:0]   wr_address;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    rd_enable;
  logic [ADDR_WIDTH-1:0]   rd_address;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
  logic                    busy;

  modport master (
    output wr_enable, wr_byte_enable, wr_address, wr_data, rd_enable, rd_address,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  wr_enable, wr_byte_enable, wr_address, wr_data, rd_enable, rd_address,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/ram_dp_pipelined.sv
// Simple dual-port RAM with byte enables, 1- or 2-cycle read latency and a valid strobe.
// Optional power-up clear sweep enabled by defining RAM_INIT_CLEAR_EN.
module ram_dp_pipelined #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned TOTAL_WORDS = 1024,
  parameter int unsigned OUTPUT_REG  = 1,
  parameter int unsigned WRITE_FIRST = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  ram_dp_pipelined_if.slave   bus
);
  localparam int unsigned         NBYTES   = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(TOTAL_WORDS);

  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("ram_dp_pipelined: DATA_WIDTH must be a multiple of 8");
  end
  if (TOTAL_WORDS > 2 ** ADDR_WIDTH) begin : g_bad_depth
    $error("ram_dp_pipelined: TOTAL_WORDS exceeds address space");
  end

  logic [DATA_WIDTH-1:0] r_mem [TOTAL_WORDS];

  logic                  w_busy;
  logic                  w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic                  w_rd_in_range;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  r_vld1;
  logic [DATA_WIDTH-1:0] r_data1;

`ifdef RAM_INIT_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(TOTAL_WORDS - 1);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic                  r_busy;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
          if (r_clr_addr == LP_LAST) begin
            r_state <= S_READY;
            r_busy  <= 1'b0;
          end
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign w_busy     = r_busy;
  assign w_clr_we   = (r_state == S_CLEAR);
  assign w_clr_addr = r_clr_addr;
`else
  assign w_busy     = 1'b0;
  assign w_clr_we   = 1'b0;
  assign w_clr_addr = '0;
`endif

  assign bus.busy      = w_busy;
  assign w_wr_fire     = bus.wr_enable && !w_busy && ({1'b0, bus.wr_address} < LP_DEPTH);
  assign w_rd_fire     = bus.rd_enable && !w_busy;
  assign w_rd_in_range = ({1'b0, bus.rd_address} < LP_DEPTH);

  always_ff @(posedge clock) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_fire) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (bus.wr_byte_enable[i]) r_mem[bus.wr_address][8*i +: 8] <= bus.wr_data[8*i +: 8];
      end
    end
  end

  // Write-first collisions are resolved by merging the incoming bytes over the stored word.
  always_comb begin
    w_rd_word = '0;
    if (w_rd_in_range) begin
      w_rd_word = r_mem[bus.rd_address];
      if (WRITE_FIRST != 0 && w_wr_fire && bus.wr_address == bus.rd_address) begin
        for (int unsigned i = 0; i < NBYTES; i++) begin
          if (bus.wr_byte_enable[i]) w_rd_word[8*i +: 8] = bus.wr_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vld1  <= 1'b0;
      r_data1 <= '0;
    end else begin
      r_vld1 <= w_rd_fire;
      if (w_rd_fire) r_data1 <= w_rd_word;
    end
  end

  if (OUTPUT_REG != 0) begin : g_oreg
    logic                  r_vld2;
    logic [DATA_WIDTH-1:0] r_data2;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_vld2  <= 1'b0;
        r_data2 <= '0;
      end else begin
        r_vld2 <= r_vld1;
        if (r_vld1) r_data2 <= r_data1;
      end
    end

    assign bus.rd_data  = r_data2;
    assign bus.rd_valid = r_vld2;
  end else begin : g_noreg
    assign bus.rd_data  = r_data1;
    assign bus.rd_valid = r_vld1;
  end
endmodule

// File: tb/tb_ram_dp_pipelined.sv
// Directed bench: dut_a (OUTPUT_REG=1, read-first, 1024 words) and dut_b (OUTPUT_REG=0,
// write-first, 1000 words) receive identical stimulus; each is checked against its own expectations.
module tb_ram_dp_pipelined;
  logic clock;
  logic reset_n;

  ram_dp_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus_a ();
  ram_dp_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus_b ();

  ram_dp_pipelined #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .TOTAL_WORDS(1024), .OUTPUT_REG(1), .WRITE_FIRST(0)
  ) dut_a (.clock(clock), .reset_n(reset_n), .bus(bus_a));

  ram_dp_pipelined #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .TOTAL_WORDS(1000), .OUTPUT_REG(0), .WRITE_FIRST(1)
  ) dut_b (.clock(clock), .reset_n(reset_n), .bus(bus_b));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_wr(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] mask,
                        input logic en);
    bus_a.wr_enable = en; bus_a.wr_address = addr; bus_a.wr_data = data; bus_a.wr_byte_enable = mask;
    bus_b.wr_enable = en; bus_b.wr_address = addr; bus_b.wr_data = data; bus_b.wr_byte_enable = mask;
  endtask

  task automatic set_rd(input logic [9:0] addr, input logic en);
    bus_a.rd_enable = en; bus_a.rd_address = addr;
    bus_b.rd_enable = en; bus_b.rd_address = addr;
  endtask

  task automatic write(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] mask);
    set_wr(addr, data, mask, 1'b1);
    tick();
    set_wr(10'd0, 32'd0, 4'd0, 1'b0);
  endtask

  // One read (optionally with a concurrent write); checks pulse position, data and hold for both DUTs.
  task automatic read_check(input string tag, input logic [9:0] raddr, input logic [31:0] ea,
                            input logic [31:0] eb, input logic do_wr, input logic [9:0] waddr,
                            input logic [31:0] wdata, input logic [3:0] wmask);
    set_rd(raddr, 1'b1);
    set_wr(waddr, wdata, wmask, do_wr);
    tick();
    set_rd(10'd0, 1'b0);
    set_wr(10'd0, 32'd0, 4'd0, 1'b0);
    check($sformatf("%s/b_vld", tag), {31'd0, bus_b.rd_valid}, 32'd1);
    check($sformatf("%s/b_dat", tag), bus_b.rd_data, eb);
    check($sformatf("%s/a_vld_early", tag), {31'd0, bus_a.rd_valid}, 32'd0);
    tick();
    check($sformatf("%s/a_vld", tag), {31'd0, bus_a.rd_valid}, 32'd1);
    check($sformatf("%s/a_dat", tag), bus_a.rd_data, ea);
    check($sformatf("%s/b_vld_off", tag), {31'd0, bus_b.rd_valid}, 32'd0);
    check($sformatf("%s/b_hold", tag), bus_b.rd_data, eb);
    tick();
    check($sformatf("%s/a_vld_off", tag), {31'd0, bus_a.rd_valid}, 32'd0);
    check($sformatf("%s/a_hold", tag), bus_a.rd_data, ea);
  endtask

  task automatic wait_ready(input int unsigned budget);
    int unsigned n = 0;
    while ((bus_a.busy || bus_b.busy) && n < budget) begin
      tick();
      n++;
    end
    check("ready", {31'd0, bus_a.busy | bus_b.busy}, 32'd0);
  endtask

`ifdef RAM_INIT_CLEAR_EN
  // Counts edges until each DUT drops busy, with rd_enable held high throughout.
  task automatic measure_sweep(input string tag);
    int unsigned n  = 0;
    int unsigned na = 0;
    int unsigned nb = 0;
    logic        va = 1'b0;
    logic        vb = 1'b0;
    set_rd(10'd0, 1'b1);
    while ((bus_a.busy || bus_b.busy) && n < 2100) begin
      tick();
      n++;
      if (bus_a.busy && bus_a.rd_valid) va = 1'b1;
      if (bus_b.busy && bus_b.rd_valid) vb = 1'b1;
      if (!bus_a.busy && na == 0) na = n;
      if (!bus_b.busy && nb == 0) nb = n;
    end
    set_rd(10'd0, 1'b0);
    check($sformatf("%s/a_cycles", tag), na, 32'd1024);
    check($sformatf("%s/b_cycles", tag), nb, 32'd1000);
    check($sformatf("%s/a_vld_busy", tag), {31'd0, va}, 32'd0);
    check($sformatf("%s/b_vld_busy", tag), {31'd0, vb}, 32'd0);
    repeat (3) tick();
  endtask
`endif

  initial begin
    logic [31:0] exp_ret;
    set_wr(10'd0, 32'd0, 4'd0, 1'b0);
    set_rd(10'd0, 1'b0);
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst/a_vld", {31'd0, bus_a.rd_valid}, 32'd0);
    check("rst/a_dat", bus_a.rd_data, 32'd0);
    check("rst/b_vld", {31'd0, bus_b.rd_valid}, 32'd0);
    check("rst/b_dat", bus_b.rd_data, 32'd0);
    @(negedge clock) reset_n = 1'b1;

`ifdef RAM_INIT_CLEAR_EN
    check("clr/busy_a", {31'd0, bus_a.busy}, 32'd1);
    measure_sweep("sweep1");
    read_check("clr_rd0", 10'd0, 32'd0, 32'd0, 1'b0, 10'd0, 32'd0, 4'd0);
    read_check("clr_rd1023", 10'd1023, 32'd0, 32'd0, 1'b0, 10'd0, 32'd0, 4'd0);
    reset_n = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    repeat (300) tick();
    reset_n = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    measure_sweep("sweep_restart");
`else
    check("busy_a", {31'd0, bus_a.busy}, 32'd0);
    check("busy_b", {31'd0, bus_b.busy}, 32'd0);
`endif
    wait_ready(2100);

    write(10'd5, 32'hDEADBEEF, 4'hF);
    read_check("full", 10'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 10'd0, 32'd0, 4'd0);
    write(10'd5, 32'h00001200, 4'b0010);
    read_check("byte1", 10'd5, 32'hDEAD12EF, 32'hDEAD12EF, 1'b0, 10'd0, 32'd0, 4'd0);
    write(10'd5, 32'hFFFFFFFF, 4'b0000);
    read_check("mask0", 10'd5, 32'hDEAD12EF, 32'hDEAD12EF, 1'b0, 10'd0, 32'd0, 4'd0);

    write(10'd7, 32'hAAAAAAAA, 4'hF);
    read_check("coll_full", 10'd7, 32'hAAAAAAAA, 32'h11111111, 1'b1, 10'd7, 32'h11111111, 4'hF);
    read_check("after_coll", 10'd7, 32'h11111111, 32'h11111111, 1'b0, 10'd0, 32'd0, 4'd0);
    write(10'd7, 32'hAAAAAAAA, 4'hF);
    read_check("coll_b0", 10'd7, 32'hAAAAAAAA, 32'hAAAAAA11, 1'b1, 10'd7, 32'h11111111, 4'b0001);
    read_check("after_b0", 10'd7, 32'hAAAAAA11, 32'hAAAAAA11, 1'b0, 10'd0, 32'd0, 4'd0);

    read_check("indep", 10'd5, 32'hDEAD12EF, 32'hDEAD12EF, 1'b1, 10'd8, 32'h00000055, 4'hF);
    read_check("indep_wr", 10'd8, 32'h00000055, 32'h00000055, 1'b0, 10'd0, 32'd0, 4'd0);

    write(10'd0, 32'h0BADF00D, 4'hF);
    write(10'd1010, 32'h12345678, 4'hF);
    read_check("oor", 10'd1010, 32'h12345678, 32'd0, 1'b0, 10'd0, 32'd0, 4'd0);
    read_check("oor_w0", 10'd0, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 10'd0, 32'd0, 4'd0);

    for (int i = 0; i < 16; i++) write(10'(i), {16'hC0DE, 16'(i)}, 4'hF);
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) set_rd(10'(k), 1'b1);
      else set_rd(10'd0, 1'b0);
      tick();
      if (k < 16) begin
        check($sformatf("burst%0d/b_vld", k), {31'd0, bus_b.rd_valid}, 32'd1);
        check($sformatf("burst%0d/b_dat", k), bus_b.rd_data, {16'hC0DE, 16'(k)});
      end else begin
        check("burst_end/b_vld", {31'd0, bus_b.rd_valid}, 32'd0);
      end
      if (k >= 1) begin
        check($sformatf("burst%0d/a_vld", k), {31'd0, bus_a.rd_valid}, 32'd1);
        check($sformatf("burst%0d/a_dat", k), bus_a.rd_data, {16'hC0DE, 16'(k - 1)});
      end else begin
        check("burst0/a_vld", {31'd0, bus_a.rd_valid}, 32'd0);
      end
    end
    tick();
    check("burst_end/a_vld", {31'd0, bus_a.rd_valid}, 32'd0);

    for (int k = 0; k < 6; k++) begin
      set_rd(10'(k), 1'b1);
      tick();
    end
    #2 reset_n = 1'b0;
    #1;
    check("midrst/a_vld", {31'd0, bus_a.rd_valid}, 32'd0);
    check("midrst/a_dat", bus_a.rd_data, 32'd0);
    check("midrst/b_vld", {31'd0, bus_b.rd_valid}, 32'd0);
    check("midrst/b_dat", bus_b.rd_data, 32'd0);
    set_rd(10'd0, 1'b0);
    @(negedge clock) reset_n = 1'b1;
    wait_ready(2100);
    tick();
    check("postrst/a_vld", {31'd0, bus_a.rd_valid}, 32'd0);
    check("postrst/b_vld", {31'd0, bus_b.rd_valid}, 32'd0);
`ifdef RAM_INIT_CLEAR_EN
    exp_ret = 32'd0;
`else
    exp_ret = 32'hC0DE0003;
`endif
    read_check("retain", 10'd3, exp_ret, exp_ret, 1'b0, 10'd0, 32'd0, 4'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
